// File: rtl/aes_dom_pkg.sv
// Shared definitions for the masked DOM AES datapath.
// Holds the state byte count, the feeder FSM state type and index helpers
// for byte slices and share interleaving (bit j of share i sits at j*D+i).
package aes_dom_pkg;

  localparam int unsigned NBYTES_C = 16;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // LSB position of byte k in a d-share state vector
  function automatic int unsigned byte_lsb(input int unsigned k, input int unsigned d);
    return k * BYTE_W * d;
  endfunction

  // Bit position of bit j of share i inside one interleaved shared byte
  function automatic int unsigned share_bit(input int unsigned j, input int unsigned i,
                                            input int unsigned d);
    return j * d + i;
  endfunction

endpackage

// File: rtl/aes_sbox_feeder_if.sv
// Bus bundle between the round controller / S-box and the S-box feeder.
// master: controller + S-box side; slave: the feeder.
//   LoadxSI, StartxSI   : load / start strobes
//   StatexDI, StatexDO  : d-share state in / out, byte k = [k*8*D +: 8*D]
//   SboxInxDO, SboxOutxDI : one interleaved shared byte to / from the S-box
//   RndEnxSO, BusyxSO, DonexSO : status
interface aes_sbox_feeder_if
  import aes_dom_pkg::*;
#(
  parameter int unsigned D      = 2,
  parameter int unsigned NBYTES = NBYTES_C
);
  localparam int unsigned BW = BYTE_W * D;
  localparam int unsigned SW = BW * NBYTES;

  logic          LoadxSI;
  logic          StartxSI;
  logic [SW-1:0] StatexDI;
  logic [SW-1:0] StatexDO;
  logic [BW-1:0] SboxInxDO;
  logic [BW-1:0] SboxOutxDI;
  logic          RndEnxSO;
  logic          BusyxSO;
  logic          DonexSO;

  modport master (
    output LoadxSI, StartxSI, StatexDI, SboxOutxDI,
    input  StatexDO, SboxInxDO, RndEnxSO, BusyxSO, DonexSO
  );

  modport slave (
    input  LoadxSI, StartxSI, StatexDI, SboxOutxDI,
    output StatexDO, SboxInxDO, RndEnxSO, BusyxSO, DonexSO
  );

endinterface

// File: rtl/aes_feeder_ctrl.sv
// Sequencer for the S-box feeder: IDLE/RUN/DONE FSM, pass counter c and the
// feed / capture byte indices and strobes derived from it.
// Ports:
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_load, i_start  : raw strobes, honoured in IDLE only
//   o_load_en_c      : capture the input state this edge
//   o_feed_en_c      : S-box input carries a real byte (constant 1 unless
//                      AES_SBOX_FEEDER_ZEROIZE_EN is defined)
//   o_feed_idx_c     : byte index driven to the S-box (saturates at NBYTES-1)
//   o_wr_en_c, o_wr_idx_c : write S-box output into this byte slot
//   o_rnd_en, o_busy, o_done : registered status
// Optional feature macro: AES_SBOX_FEEDER_ZEROIZE_EN.
module aes_feeder_ctrl
  import aes_dom_pkg::*;
#(
  parameter  int unsigned NBYTES   = NBYTES_C,
  parameter  int unsigned SBOX_LAT = 5,
  localparam int unsigned CW       = $clog2(NBYTES + SBOX_LAT),
  localparam int unsigned IW       = $clog2(NBYTES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_start,
  output logic          o_load_en_c,
  output logic          o_feed_en_c,
  output logic [IW-1:0] o_feed_idx_c,
  output logic          o_wr_en_c,
  output logic [IW-1:0] o_wr_idx_c,
  output logic          o_rnd_en,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1 + SBOX_LAT);
  localparam logic [CW-1:0] CNT_NB   = CW'(NBYTES);
  localparam logic [CW-1:0] CNT_LAT  = CW'(SBOX_LAT);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  fsm_state_e    r_fsm, w_fsm_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_rnd_en, r_busy, r_done;
  logic          w_rnd_en_nxt, w_busy_nxt, w_done_nxt;

  // State, counter and status registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm    <= IDLE;
      r_cnt    <= '0;
      r_rnd_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_fsm    <= w_fsm_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rnd_en <= w_rnd_en_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next state / counter; status is decoded from the next state so it is
  // registered yet aligned with the state it describes
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_cnt_nxt = r_cnt;
    unique case (r_fsm)
      IDLE: begin
        if (i_start) begin
          w_fsm_nxt = RUN;
          w_cnt_nxt = '0;
        end
      end
      RUN: begin
        // c stops at its last value so the feed mux keeps selecting byte NBYTES-1
        if (r_cnt == CNT_LAST) w_fsm_nxt = DONE;
        else                   w_cnt_nxt = r_cnt + CW'(1);
      end
      DONE:    w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
    w_rnd_en_nxt = (w_fsm_nxt == RUN);
    w_busy_nxt   = (w_fsm_nxt != IDLE);
    w_done_nxt   = (w_fsm_nxt == DONE);
  end

  // Datapath strobes and indices
  always_comb begin
    o_load_en_c  = (r_fsm == IDLE) && i_load;
    o_feed_idx_c = (r_cnt >= CNT_NB) ? IDX_LAST : IW'(r_cnt);
    o_wr_en_c    = (r_fsm == RUN) && (r_cnt >= CNT_LAT);
    o_wr_idx_c   = IW'(r_cnt - CNT_LAT);
`ifdef AES_SBOX_FEEDER_ZEROIZE_EN
    o_feed_en_c  = (r_fsm == RUN) && (r_cnt < CNT_NB);
`else
    o_feed_en_c  = 1'b1;
`endif
  end

  assign o_rnd_en = r_rnd_en;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: rtl/aes_sbox_feeder.sv
// Byte-serial front/back end of the pipelined masked DOM S-box.
// Holds the d-share AES state, streams one shared byte per cycle to the
// S-box and writes each result back SBOX_LAT cycles later into the same slot.
// Shares are only moved, never combined.
// Ports:
//   ClkxCI  : clock, rising edge
//   RstxBI  : async active-low reset
//   bus     : aes_sbox_feeder_if.slave (load/start, state in/out,
//             S-box in/out, RndEn/Busy/Done)
// Optional feature macro: AES_SBOX_FEEDER_ZEROIZE_EN (S-box input forced to
// zero outside feed cycles).
module aes_sbox_feeder
  import aes_dom_pkg::*;
#(
  parameter int unsigned D        = 2,
  parameter int unsigned SBOX_LAT = 5,
  parameter int unsigned NBYTES   = NBYTES_C
) (
  input  logic              ClkxCI,
  input  logic              RstxBI,
  aes_sbox_feeder_if.slave  bus
);

  localparam int unsigned BW = BYTE_W * D;
  localparam int unsigned IW = $clog2(NBYTES);

  logic [NBYTES-1:0][BW-1:0] r_state;
  logic                      w_load_en;
  logic                      w_feed_en;
  logic [IW-1:0]             w_feed_idx;
  logic                      w_wr_en;
  logic [IW-1:0]             w_wr_idx;

  aes_feeder_ctrl #(
    .NBYTES   (NBYTES),
    .SBOX_LAT (SBOX_LAT)
  ) u_ctrl (
    .i_clk        (ClkxCI),
    .i_rst_n      (RstxBI),
    .i_load       (bus.LoadxSI),
    .i_start      (bus.StartxSI),
    .o_load_en_c  (w_load_en),
    .o_feed_en_c  (w_feed_en),
    .o_feed_idx_c (w_feed_idx),
    .o_wr_en_c    (w_wr_en),
    .o_wr_idx_c   (w_wr_idx),
    .o_rnd_en     (bus.RndEnxSO),
    .o_busy       (bus.BusyxSO),
    .o_done       (bus.DonexSO)
  );

  // State register: bulk load in IDLE, per-byte write-back in RUN
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_state <= '0;
    end else if (w_load_en) begin
      r_state <= bus.StatexDI;
    end else if (w_wr_en) begin
      r_state[w_wr_idx] <= bus.SboxOutxDI;
    end
  end

  assign bus.StatexDO  = r_state;
  assign bus.SboxInxDO = w_feed_en ? r_state[w_feed_idx] : '0;

endmodule

// File: tb/tb_aes_sbox_feeder.sv
// Directed bench for aes_sbox_feeder with a behavioural shared S-box model.
module tb_aes_sbox_feeder;
  import aes_dom_pkg::*;

  localparam int unsigned D        = 2;
  localparam int unsigned LAT      = 5;
  localparam int unsigned NB       = NBYTES_C;
  localparam int unsigned BW       = 8 * D;
  localparam int unsigned SW       = BW * NB;
  localparam int unsigned EXP_DONE = NB + LAT + 1;
  localparam int unsigned EXP_RND  = NB + LAT;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // Hand-written SubBytes of 00..0f
  localparam logic [7:0] EXP_A [16] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,
    8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic mask_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aes_sbox_feeder_if #(.D(D), .NBYTES(NB)) bus ();

  aes_sbox_feeder #(.D(D), .SBOX_LAT(LAT), .NBYTES(NB)) dut (
    .ClkxCI (clk),
    .RstxBI (rst_n),
    .bus    (bus)
  );

  function automatic logic [BW-1:0] ilv(input logic [7:0] s0, input logic [7:0] s1);
    logic [BW-1:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r[share_bit(j, 0, D)] = s0[j];
      r[share_bit(j, 1, D)] = s1[j];
    end
    return r;
  endfunction

  function automatic logic [7:0] sh(input logic [BW-1:0] b, input int i);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = b[share_bit(j, i, D)];
    return r;
  endfunction

  function automatic logic [7:0] st_byte(input logic [SW-1:0] st, input int k, input int i);
    return sh(st[byte_lsb(k, D) +: BW], i);
  endfunction

  // Shared S-box model: unmask, look up, re-share with a fresh mask, LAT cycles later
  logic [7:0] pipe_x [LAT];
  logic [7:0] pipe_m [LAT];

  always_ff @(posedge clk) begin
    pipe_x[0] <= sh(bus.SboxInxDO, 0) ^ sh(bus.SboxInxDO, 1);
    pipe_m[0] <= mask_en ? 8'($urandom) : 8'h00;
    for (int i = 1; i < LAT; i++) begin
      pipe_x[i] <= pipe_x[i-1];
      pipe_m[i] <= pipe_m[i-1];
    end
  end

  always_comb bus.SboxOutxDI = ilv(SBOX[pipe_x[LAT-1]] ^ pipe_m[LAT-1], pipe_m[LAT-1]);

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the start edge; returns in the first IDLE cycle
  task automatic run_to_done(input bit glitch, input bit chk_feed, input logic [SW-1:0] fed,
                             output int done_cyc, output int rnd_cyc, output int busy_cyc,
                             output logic [SW-1:0] st_done);
    done_cyc = 0;
    rnd_cyc  = 0;
    busy_cyc = 0;
    st_done  = '0;
    for (int n = 1; n <= 100; n++) begin
      if (bus.RndEnxSO) rnd_cyc++;
      if (bus.BusyxSO)  busy_cyc++;
      if (chk_feed && n <= int'(NB))
        chk($sformatf("feed_byte%0d", n - 1), SW'(bus.SboxInxDO),
            SW'(fed[byte_lsb(n - 1, D) +: BW]));
      if (chk_feed && n == int'(NB) + 1) begin
`ifdef AES_SBOX_FEEDER_ZEROIZE_EN
        chk("post_feed_sboxin", SW'(bus.SboxInxDO), '0);
`else
        chk("post_feed_sboxin", SW'(bus.SboxInxDO), SW'(fed[byte_lsb(NB - 1, D) +: BW]));
`endif
      end
      if (bus.DonexSO) begin
        done_cyc = n;
        st_done  = bus.StatexDO;
        break;
      end
      if (glitch && n == 4) begin
        bus.LoadxSI  = 1'b1;
        bus.StartxSI = 1'b1;
        bus.StatexDI = ~fed;
      end
      tick();
      bus.LoadxSI  = 1'b0;
      bus.StartxSI = 1'b0;
    end
    if (glitch) begin
      bus.LoadxSI  = 1'b1;
      bus.StartxSI = 1'b1;
      bus.StatexDI = ~fed;
    end
    tick();
    bus.LoadxSI  = 1'b0;
    bus.StartxSI = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] va, exp_a, exp_b, vm, st;
    logic [SW-1:0] unm, exp_m;
    logic [7:0]    x, m;
    int            dc, rc, bc, cnt;

    bus.LoadxSI  = 1'b0;
    bus.StartxSI = 1'b0;
    bus.StatexDI = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",  bus.StatexDO, '0);
    chk("reset_sboxin", SW'(bus.SboxInxDO), '0);
    chk("reset_busy",   SW'(bus.BusyxSO), '0);
    chk("reset_done",   SW'(bus.DonexSO), '0);
    chk("reset_rnden",  SW'(bus.RndEnxSO), '0);
    rst_n = 1'b1;
    tick();

    va = '0; exp_a = '0; exp_b = '0; vm = '0; exp_m = '0;
    for (int k = 0; k < int'(NB); k++) begin
      va[byte_lsb(k, D) +: BW]    = ilv(8'(k), 8'h00);
      exp_a[byte_lsb(k, D) +: BW] = ilv(EXP_A[k], 8'h00);
      exp_b[byte_lsb(k, D) +: BW] = ilv(SBOX[EXP_A[k]], 8'h00);
    end

    // Pass A: Load and Start together, unmasked
    bus.StatexDI = va;
    bus.LoadxSI  = 1'b1;
    bus.StartxSI = 1'b1;
    tick();
    bus.LoadxSI  = 1'b0;
    bus.StartxSI = 1'b0;
    run_to_done(1'b0, 1'b1, va, dc, rc, bc, st);
    chk("a_done_cycle", SW'(dc), SW'(EXP_DONE));
    chk("a_rnden_cycles", SW'(rc), SW'(EXP_RND));
    chk("a_busy_cycles", SW'(bc), SW'(EXP_DONE));
    chk("a_state", st, exp_a);
    chk("a_idle_busy", SW'(bus.BusyxSO), '0);
`ifdef AES_SBOX_FEEDER_ZEROIZE_EN
    chk("a_idle_sboxin", SW'(bus.SboxInxDO), '0);
`else
    chk("a_idle_sboxin", SW'(bus.SboxInxDO), SW'(ilv(8'h76, 8'h00)));
`endif

    // Back-to-back: Start in the first IDLE cycle, no reload
    bus.StartxSI = 1'b1;
    tick();
    bus.StartxSI = 1'b0;
    run_to_done(1'b0, 1'b0, '0, dc, rc, bc, st);
    chk("b_done_cycle", SW'(dc), SW'(EXP_DONE));
    chk("b_rnden_cycles", SW'(rc), SW'(EXP_RND));
    chk("b_state", st, exp_b);
    chk("b_byte0_share0", SW'(st_byte(st, 0, 0)), SW'(8'hfb));

    // Masked pass: separate load, random nonzero input masks, re-masked outputs
    for (int k = 0; k < int'(NB); k++) begin
      x = 8'(k * 17 + 3);
      m = 8'($urandom_range(1, 255));
      vm[byte_lsb(k, D) +: BW] = ilv(x ^ m, m);
      exp_m[k*8 +: 8]          = SBOX[x];
    end
    bus.StatexDI = vm;
    bus.LoadxSI  = 1'b1;
    tick();
    bus.LoadxSI  = 1'b0;
    chk("m_load_only", bus.StatexDO, vm);
    chk("m_load_busy", SW'(bus.BusyxSO), '0);
    mask_en = 1'b1;
    bus.StartxSI = 1'b1;
    tick();
    bus.StartxSI = 1'b0;
    run_to_done(1'b0, 1'b1, vm, dc, rc, bc, st);
    mask_en = 1'b0;
    unm = '0;
    for (int k = 0; k < int'(NB); k++) unm[k*8 +: 8] = st_byte(st, k, 0) ^ st_byte(st, k, 1);
    chk("m_done_cycle", SW'(dc), SW'(EXP_DONE));
    chk("m_unmasked", unm, exp_m);

    // Load/Start pulsed at c=3 and in DONE must be ignored
    bus.StatexDI = va;
    bus.LoadxSI  = 1'b1;
    bus.StartxSI = 1'b1;
    tick();
    bus.LoadxSI  = 1'b0;
    bus.StartxSI = 1'b0;
    run_to_done(1'b1, 1'b0, va, dc, rc, bc, st);
    chk("g_done_cycle", SW'(dc), SW'(EXP_DONE));
    chk("g_state", st, exp_a);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (bus.DonexSO || bus.BusyxSO) cnt++;
      tick();
    end
    chk("g_no_restart", SW'(cnt), '0);
    chk("g_state_after", bus.StatexDO, exp_a);

    // Reset mid-pass at c=7
    bus.StatexDI = va;
    bus.LoadxSI  = 1'b1;
    bus.StartxSI = 1'b1;
    tick();
    bus.LoadxSI  = 1'b0;
    bus.StartxSI = 1'b0;
    repeat (7) tick();
    chk("r_busy_before", SW'(bus.BusyxSO), SW'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("r_state",  bus.StatexDO, '0);
    chk("r_busy",   SW'(bus.BusyxSO), '0);
    chk("r_sboxin", SW'(bus.SboxInxDO), '0);
    chk("r_rnden",  SW'(bus.RndEnxSO), '0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      if (bus.DonexSO) cnt++;
      tick();
    end
    chk("r_no_done", SW'(cnt), '0);
    bus.LoadxSI  = 1'b1;
    bus.StartxSI = 1'b1;
    tick();
    bus.LoadxSI  = 1'b0;
    bus.StartxSI = 1'b0;
    run_to_done(1'b0, 1'b0, va, dc, rc, bc, st);
    chk("r_after_done_cycle", SW'(dc), SW'(EXP_DONE));
    chk("r_after_state", st, exp_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
